// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction prefetch queue.
package fetch_pkg;

  localparam int N  = 64;
  localparam int IW = 32;

  typedef struct packed {
    logic [N-1:0]  pc;
    logic [IW-1:0] instr;
  } fq_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_queue_wrap_ptr.sv
// Free-running pointer of W bits that wraps naturally; clr returns it to zero.
module wrap_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Pointer register: reset and clear both return to slot 0, otherwise step on inc.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_q <= '0;
    end else if (inc) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule : wrap_ptr

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode. Fetch pushes {PC, instr},
// decode pops in order with first-word-fall-through outputs. A taken branch
// (flush) discards every queued wrong-path entry.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int N     = 64,
  parameter int IW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_F,
  input  logic [N-1:0]               pc_F,
  input  logic [IW-1:0]              instr_F,
  output logic                       full_F,
  input  logic                       flush,
  input  logic                       pop_D,
  output logic                       valid_D,
  output logic [N-1:0]               pc_D,
  output logic [IW-1:0]              instr_D,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of 2 and at least 2");
  end
  if (N != fetch_pkg::N || IW != fetch_pkg::IW) begin : g_bad_width
    $error("fetch_queue: N/IW must match the entry type in fetch_pkg");
  end

  fq_entry_t       r_mem [DEPTH];
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   w_rd_ptr;
  logic [PW-1:0]   w_wr_ptr;
  logic            w_push_ok;
  logic            w_pop_ok;
  fq_entry_t       w_head;
  fq_entry_t       w_entry_in;

  assign full_F  = (r_count == FULL_CNT);
  assign valid_D = (r_count != '0);

  // A flush cycle ignores push and pop entirely.
  assign w_push_ok = push_F && !full_F && !flush;
  assign w_pop_ok  = pop_D && valid_D && !flush;

  assign w_entry_in.pc    = pc_F;
  assign w_entry_in.instr = instr_F;

  wrap_ptr #(.W(PW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (w_pop_ok),
    .q     (w_rd_ptr)
  );

  wrap_ptr #(.W(PW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (w_push_ok),
    .q     (w_wr_ptr)
  );

  // Storage is written only on an accepted push; it is never reset because
  // unwritten slots are hidden behind valid_D.
  always_ff @(posedge clk) begin
    if (!reset && w_push_ok) begin
      r_mem[w_wr_ptr] <= w_entry_in;
    end
  end

  // Occupancy tracked explicitly so a full queue is distinguishable from empty.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_count <= '0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign count  = r_count;
  assign w_head = r_mem[w_rd_ptr];

  // Head outputs are forced to zero when empty so stale slots never leak out.
  always_comb begin
    pc_D    = '0;
    instr_D = '0;
    if (valid_D) begin
      pc_D    = w_head.pc;
      instr_D = w_head.instr;
    end
  end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: accepted pushes are queued as expectations,
// and every accepted pop compares the presented head against the queue front.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          push_F;
  logic [N-1:0]  pc_F;
  logic [IW-1:0] instr_F;
  logic          full_F;
  logic          flush;
  logic          pop_D;
  logic          valid_D;
  logic [N-1:0]  pc_D;
  logic [IW-1:0] instr_D;
  logic [CW-1:0] count;

  fq_entry_t sbq[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_queue #(.N(N), .IW(IW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .push_F  (push_F),
    .pc_F    (pc_F),
    .instr_F (instr_F),
    .full_F  (full_F),
    .flush   (flush),
    .pop_D   (pop_D),
    .valid_D (valid_D),
    .pc_D    (pc_D),
    .instr_D (instr_D),
    .count   (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the scoreboard's view of the queue.
  task automatic check_outputs(input string tag);
    logic [63:0] exp_pc;
    logic [63:0] exp_ins;
    exp_pc  = '0;
    exp_ins = '0;
    if (sbq.size() > 0) begin
      exp_pc  = sbq[0].pc;
      exp_ins = 64'(sbq[0].instr);
    end
    chk({tag, ":count"}, 64'(count), 64'(sbq.size()));
    chk({tag, ":valid"}, 64'(valid_D), 64'(sbq.size() != 0));
    chk({tag, ":full"},  64'(full_F),  64'(sbq.size() == DEPTH));
    chk({tag, ":pc"},    pc_D,         exp_pc);
    chk({tag, ":instr"}, 64'(instr_D), exp_ins);
  endtask

  // One clock: drive, check before the edge, update the scoreboard, pass the edge.
  task automatic cycle(input string tag, input bit rst, input bit psh,
                       input logic [63:0] pc, input logic [31:0] ins,
                       input bit pp, input bit fl);
    bit push_ok;
    bit pop_ok;
    fq_entry_t e;
    reset   = rst;
    push_F  = psh;
    pc_F    = pc;
    instr_F = ins;
    pop_D   = pp;
    flush   = fl;
    @(negedge clk);
    check_outputs(tag);
    if (rst || fl) begin
      sbq.delete();
    end else begin
      push_ok = psh && (sbq.size() < DEPTH);
      pop_ok  = pp && (sbq.size() > 0);
      if (pop_ok) void'(sbq.pop_front());
      if (push_ok) begin
        e.pc    = pc;
        e.instr = ins;
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    push_F  = 1'b0;
    pc_F    = '0;
    instr_F = '0;
    pop_D   = 1'b0;
    flush   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t1_valid", 64'(valid_D), 64'd0);
    chk("t1_full",  64'(full_F),  64'd0);
    chk("t1_count", 64'(count),   64'd0);
    chk("t1_pc",    pc_D,         64'd0);
    chk("t1_instr", 64'(instr_D), 64'd0);

    // Fill to full, then a refused push.
    for (int i = 0; i < 4; i++)
      cycle("t2_push", 0, 1, 64'(4 * i), 32'(32'hA0 + i), 0, 0);
    chk("t2_count", 64'(count),  64'd4);
    chk("t2_full",  64'(full_F), 64'd1);
    cycle("t2_refused", 0, 1, 64'h10, 32'hA4, 0, 0);
    chk("t2_count_held", 64'(count), 64'd4);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      chk("t3_pc_seq", pc_D, 64'(4 * i));
      cycle("t3_pop", 0, 0, 64'd0, 32'd0, 1, 0);
    end
    chk("t3_valid_empty", 64'(valid_D), 64'd0);
    chk("t3_pc_empty",    pc_D,         64'd0);

    // Push and pop together past the wrap point; occupancy stays at one.
    cycle("t4_prime", 0, 1, 64'h100, 32'hB0, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      cycle("t4_stream", 0, 1, 64'(32'h100 + 4 * i), 32'(32'hB0 + i), 1, 0);
      chk("t4_count", 64'(count), 64'd1);
      chk("t4_lag",   pc_D,       64'(32'h100 + 4 * i));
    end
    cycle("t4_drain", 0, 0, 64'd0, 32'd0, 1, 0);

    // Flush discards entries and ignores the concurrent push and pop.
    for (int i = 0; i < 3; i++)
      cycle("t5_fill", 0, 1, 64'(32'h40 + 4 * i), 32'(32'hC0 + i), 0, 0);
    cycle("t5_flush", 0, 1, 64'h4C, 32'hC3, 1, 1);
    chk("t5_count", 64'(count),   64'd0);
    chk("t5_valid", 64'(valid_D), 64'd0);
    cycle("t5_push", 0, 1, 64'hfff0, 32'hD0, 0, 0);
    chk("t5_pc", pc_D, 64'hfff0);
    cycle("t5_pop", 0, 0, 64'd0, 32'd0, 1, 0);

    // Full queue: pop wins, push refused; then reset mid-stream.
    for (int i = 0; i < 4; i++)
      cycle("t6_fill", 0, 1, 64'(32'h200 + 4 * i), 32'(32'hE0 + i), 0, 0);
    cycle("t6_full_pp", 0, 1, 64'h300, 32'hEF, 1, 0);
    chk("t6_count3", 64'(count), 64'd3);
    cycle("t6_pop", 0, 0, 64'd0, 32'd0, 1, 0);
    chk("t6_count2", 64'(count), 64'd2);
    chk("t6_head",   pc_D,       64'h208);
    cycle("t6_reset", 1, 1, 64'h400, 32'hF0, 1, 0);
    chk("t6_count_rst", 64'(count),   64'd0);
    chk("t6_valid_rst", 64'(valid_D), 64'd0);
    cycle("t6_idle", 0, 0, 64'd0, 32'd0, 1, 0);
    @(negedge clk);
    check_outputs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fetch_queue
